// File: rtl/decode.sv
// RV32I decode stage: registers the fetched instruction and PC, and splits it into
// register addresses, immediate, ALU op, one-hot class and an illegal flag for execute.
module decode #(
  parameter logic [31:0] PC_RESET = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  input  logic        clk_en,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  rs1_raddr,
  output logic [4:0]  rs2_raddr,
  output logic [31:0] decode_instr,
  output logic [31:0] decode_pc,
  output logic [4:0]  decode_rs1_addr,
  output logic [4:0]  decode_rs2_addr,
  output logic [4:0]  decode_rd_addr,
  output logic [31:0] decode_imm,
  output logic [2:0]  decode_funct3,
  output logic [3:0]  decode_alu_op,
  output logic [10:0] decode_type,
  output logic        decode_valid,
  output logic        decode_illegal,
  output logic        next_clk_en
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam int T_R = 0, T_IARITH = 1, T_LOAD = 2, T_STORE = 3, T_BRANCH = 4, T_JAL = 5;
  localparam int T_JALR = 6, T_LUI = 7, T_AUIPC = 8, T_SYSTEM = 9, T_FENCE = 10;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [10:0] type_d;
  logic        illegal_d;
  logic [3:0]  alu_d;
  logic [31:0] imm_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  logic [31:0] instr_q, pc_q, imm_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [2:0]  funct3_q;
  logic [3:0]  alu_q;
  logic [10:0] type_q;
  logic        valid_q, illegal_q;

  assign opcode = fetch_instr[6:0];
  assign funct3 = fetch_instr[14:12];
  assign funct7 = fetch_instr[31:25];

  assign imm_i = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
  assign imm_s = {{20{fetch_instr[31]}}, fetch_instr[31:25], fetch_instr[11:7]};
  assign imm_b = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
                  fetch_instr[30:25], fetch_instr[11:8], 1'b0};
  assign imm_u = {fetch_instr[31:12], 12'b0};
  assign imm_j = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
                  fetch_instr[20], fetch_instr[30:21], 1'b0};

  // Opcode includes instr[1:0], so compressed encodings fall through to default.
  always_comb begin
    type_d    = '0;
    illegal_d = 1'b0;
    case (opcode)
      OP_R: begin
        type_d[T_R] = 1'b1;
        illegal_d   = !((funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_IARITH: begin
        type_d[T_IARITH] = 1'b1;
        illegal_d = (funct3 == 3'b001 && funct7 != 7'h00) ||
                    (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20);
      end
      OP_LOAD: begin
        type_d[T_LOAD] = 1'b1;
        illegal_d = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        type_d[T_STORE] = 1'b1;
        illegal_d = (funct3 >= 3'b011);
      end
      OP_BRANCH: begin
        type_d[T_BRANCH] = 1'b1;
        illegal_d = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL:    type_d[T_JAL] = 1'b1;
      OP_JALR: begin
        type_d[T_JALR] = 1'b1;
        illegal_d = (funct3 != 3'b000);
      end
      OP_LUI:    type_d[T_LUI]    = 1'b1;
      OP_AUIPC:  type_d[T_AUIPC]  = 1'b1;
      OP_SYSTEM: type_d[T_SYSTEM] = 1'b1;
      OP_FENCE:  type_d[T_FENCE]  = 1'b1;
      default:   illegal_d = 1'b1;
    endcase
    if (illegal_d) type_d = '0;
  end

  // An illegal instruction has no class, so it gets no immediate, no rs2 and no rd.
  always_comb begin
    imm_d = '0;
    if (type_d[T_IARITH] || type_d[T_LOAD] || type_d[T_JALR]) imm_d = imm_i;
    else if (type_d[T_STORE])                                 imm_d = imm_s;
    else if (type_d[T_BRANCH])                                imm_d = imm_b;
    else if (type_d[T_LUI] || type_d[T_AUIPC])                imm_d = imm_u;
    else if (type_d[T_JAL])                                   imm_d = imm_j;
  end

  always_comb begin
    alu_d = ALU_ADD;
    if (type_d[T_R] || type_d[T_IARITH]) begin
      case (funct3)
        3'b000:  alu_d = (type_d[T_R] && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_d = ALU_SLL;
        3'b010:  alu_d = ALU_SLT;
        3'b011:  alu_d = ALU_SLTU;
        3'b100:  alu_d = ALU_XOR;
        3'b101:  alu_d = funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_d = ALU_OR;
        default: alu_d = ALU_AND;
      endcase
    end else if (type_d[T_BRANCH]) begin
      case (funct3[2:1])
        2'b00:   alu_d = ALU_SUB;
        2'b10:   alu_d = ALU_SLT;
        2'b11:   alu_d = ALU_SLTU;
        default: alu_d = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    rs1_d = (type_d[T_LUI] || type_d[T_AUIPC] || type_d[T_JAL]) ? 5'd0 : fetch_instr[19:15];
    rs2_d = (type_d[T_R] || type_d[T_STORE] || type_d[T_BRANCH]) ? fetch_instr[24:20] : 5'd0;
    rd_d  = (illegal_d || type_d[T_STORE] || type_d[T_BRANCH] || type_d[T_FENCE])
            ? 5'd0 : fetch_instr[11:7];
  end

  always_ff @(posedge clk) begin
    if (!rst || (clk_en && flush)) begin
      instr_q   <= NOP;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      funct3_q  <= '0;
      alu_q     <= '0;
      type_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      if (!rst) pc_q <= PC_RESET;
    end else if (clk_en && !stall) begin
      instr_q   <= fetch_instr;
      pc_q      <= fetch_pc;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      funct3_q  <= funct3;
      alu_q     <= alu_d;
      type_q    <= type_d;
      valid_q   <= 1'b1;
      illegal_q <= illegal_d;
    end
  end

  assign rs1_raddr       = fetch_instr[19:15];
  assign rs2_raddr       = fetch_instr[24:20];
  assign next_clk_en     = clk_en && !stall;
  assign decode_instr    = instr_q;
  assign decode_pc       = pc_q;
  assign decode_rs1_addr = rs1_q;
  assign decode_rs2_addr = rs2_q;
  assign decode_rd_addr  = rd_q;
  assign decode_imm      = imm_q;
  assign decode_funct3   = funct3_q;
  assign decode_alu_op   = alu_q;
  assign decode_type     = type_q;
  assign decode_valid    = valid_q;
  assign decode_illegal  = illegal_q;

endmodule
